// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Also holds the ARM condition-code evaluator.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Raw per-state controls before condition gating.
    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       regw;
        logic       memw;
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic       aluop;
        logic [1:0] resultsrc;
        logic [1:0] alusrcb;
    } raw_ctrl_t;

    // flags = {N, Z, C, V}; code 1111 never holds.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bus: instruction/flags in, control strobes and selects out.
interface arm_mc_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/arm_cond_unit.sv
// NZCV flags register plus the condition-pass bit latched once per instruction.
module arm_cond_unit
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       latch_en,
    output logic       cond_ex
);

    logic [3:0] flags_reg;
    logic       cond_ex_reg;

    // flag_w[1] covers N,Z and flag_w[0] covers C,V; both gated by this instruction's pass bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_reg   <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            if (latch_en)
                cond_ex_reg <= cond_holds(cond, flags_reg);
            if (cond_ex_reg && flag_w[1])
                flags_reg[3:2] <= alu_flags[3:2];
            if (cond_ex_reg && flag_w[0])
                flags_reg[1:0] <= alu_flags[1:0];
        end
    end

    assign cond_ex = cond_ex_reg;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback
// and gates architectural writes by the latched condition result.
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    arm_mc_controller_if.master        bus
);

    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        unused_instr_bits;

    assign instr = bus.Instr;
    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign rd    = instr[15:12];
    assign unused_instr_bits = &{1'b0, instr[19:16], instr[11:0]};

    state_t    state_reg, state_next;
    raw_ctrl_t ctrl;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       no_write;
    logic       cond_ex;
    logic       reg_wr_ok;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_reg <= FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:   state_next = funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_reg)
            FETCH: begin
                ctrl.irwrite   = 1'b1;
                ctrl.next_pc   = 1'b1;
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            MEMADR: ctrl.alusrcb = SRCB_EXTIMM;
            MEMRD:  ctrl.adrsrc  = 1'b1;
            MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regw      = 1'b1;
            end
            MEMWR: begin
                ctrl.adrsrc = 1'b1;
                ctrl.memw   = 1'b1;
            end
            EXECR: begin
                ctrl.aluop   = 1'b1;
                ctrl.alusrcb = SRCB_RD2;
            end
            EXECI: begin
                ctrl.aluop   = 1'b1;
                ctrl.alusrcb = SRCB_EXTIMM;
            end
            ALUWB:  ctrl.regw = 1'b1;
            BRANCH: begin
                ctrl.branch    = 1'b1;
                ctrl.alusrcb   = SRCB_EXTIMM;
                ctrl.resultsrc = RES_ALURESULT;
            end
            default: ctrl = '0;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        if (ctrl.aluop) begin
            case (funct[4:1])
                4'b0100: alu_control = ALU_ADD;
                4'b0010: alu_control = ALU_SUB;
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
                4'b1010: alu_control = ALU_SUB;
                default: alu_control = ALU_ADD;
            endcase
        end
        flag_w[1] = ctrl.aluop & funct[0];
        flag_w[0] = ctrl.aluop & funct[0] & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
    end

    // CMP must also suppress the write in ALUWB, where ALUOp is already 0,
    // so NoWrite is decoded from the (stable) instruction rather than the ALU decode.
    assign no_write = (op == OP_DP) && (funct[4:1] == 4'b1010);

    arm_cond_unit u_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .cond      (cond),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w),
        .latch_en  (state_reg == DECODE),
        .cond_ex   (cond_ex)
    );

    assign reg_wr_ok = ctrl.regw & cond_ex & ~no_write;

    assign bus.PCWrite    = reset_n & (ctrl.next_pc | (ctrl.branch & cond_ex) | (reg_wr_ok & (rd == 4'hF)));
    assign bus.RegWrite   = reset_n & reg_wr_ok;
    assign bus.MemWrite   = reset_n & ctrl.memw & cond_ex;
    assign bus.IRWrite    = reset_n & ctrl.irwrite;
    assign bus.AdrSrc     = ctrl.adrsrc;
    assign bus.ResultSrc  = ctrl.resultsrc;
    assign bus.ALUSrcA    = ctrl.alusrca;
    assign bus.ALUSrcB    = ctrl.alusrcb;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Cycle-level scoreboard bench for arm_mc_controller: expected control vectors
// are queued as stimulus is applied and compared when sampled mid-cycle.
module tb_arm_mc_controller;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    arm_mc_controller_if bus_if();

    arm_mc_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                  S_EXECR, S_EXECI, S_ALUWB, S_BRANCH} tst_e;
    typedef enum {K_DPR, K_DPI, K_LDR, K_STR, K_B, K_UND} kind_e;
    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic [15:0] mask;
    } sb_item_t;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc}
    localparam logic [15:0] WE_MASK = 16'b1011_1000_0000_0000;

    sb_item_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_vec();
        return {bus_if.PCWrite, bus_if.AdrSrc, bus_if.MemWrite, bus_if.IRWrite, bus_if.RegWrite,
                bus_if.ResultSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUControl,
                bus_if.ImmSrc, bus_if.RegSrc};
    endfunction

    // Reference control vector taken from the per-state control table.
    function automatic logic [15:0] exp_vec(input tst_e st, input logic [31:0] ins, input logic cx);
        logic       pcw, adr, memw, irw, regw, srca, is_cmp;
        logic [1:0] res, srcb, aluc, op;
        logic [5:0] fn;
        logic [3:0] rd;
        op = ins[27:26];
        fn = ins[25:20];
        rd = ins[15:12];
        is_cmp = (op == 2'b00) && (fn[4:1] == 4'b1010);
        pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; srca = 0;
        res = 2'b00; srcb = 2'b00; aluc = 2'b00;
        case (st)
            S_FETCH:  begin irw = 1; pcw = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
            S_DECODE: begin srca = 1; srcb = 2'b10; res = 2'b10; end
            S_MEMADR: srcb = 2'b01;
            S_MEMRD:  adr = 1;
            S_MEMWB:  begin res = 2'b01; regw = cx; pcw = cx && (rd == 4'hF); end
            S_MEMWR:  begin adr = 1; memw = cx; end
            S_EXECR, S_EXECI: begin
                srcb = (st == S_EXECI) ? 2'b01 : 2'b00;
                case (fn[4:1])
                    4'b0010: aluc = 2'b01;
                    4'b0000: aluc = 2'b10;
                    4'b1100: aluc = 2'b11;
                    4'b1010: aluc = 2'b01;
                    default: aluc = 2'b00;
                endcase
            end
            S_ALUWB:  begin regw = cx & ~is_cmp; pcw = regw && (rd == 4'hF); end
            S_BRANCH: begin pcw = cx; srcb = 2'b01; res = 2'b10; end
            default: ;
        endcase
        return {pcw, adr, memw, irw, regw, res, srca, srcb, aluc, op, op == 2'b01, op == 2'b10};
    endfunction

    // One clock: drive inputs, queue the expectation, sample at the falling edge.
    task automatic cycle(input string tag, input tst_e st, input logic [31:0] ins,
                         input logic [3:0] af, input logic cx, input logic rst_n);
        sb_item_t it;
        sb_item_t got;
        reset_n = rst_n;
        bus_if.Instr = ins;
        bus_if.ALUFlags = af;
        it.tag  = tag;
        it.exp  = rst_n ? exp_vec(st, ins, cx) : 16'h0000;
        it.mask = rst_n ? 16'hFFFF : WE_MASK;
        sb_q.push_back(it);
        @(negedge clk);
        got = sb_q.pop_front();
        chk_eq(got.tag, obs_vec() & got.mask, got.exp & got.mask);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input kind_e k, input logic [31:0] ins,
                       input logic [3:0] af, input logic cx);
        tst_e path[$];
        case (k)
            K_DPR:   path = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
            K_DPI:   path = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
            K_LDR:   path = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
            K_STR:   path = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
            K_B:     path = '{S_FETCH, S_DECODE, S_BRANCH};
            default: path = '{S_FETCH, S_DECODE};
        endcase
        foreach (path[i])
            cycle($sformatf("%s.c%0d", name, i), path[i], ins, af, cx, 1'b1);
        $display("txn %-10s instr=%h cycles=%0d compared=%0d", name, ins, path.size(), n_cmp);
    endtask

    function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] cmd,
                                       input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] imm);
        return {c, 2'b00, i, cmd, s, rn, rd, imm};
    endfunction

    function automatic logic [31:0] mem(input logic [3:0] c, input logic [5:0] fn,
                                        input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] imm);
        return {c, 2'b01, fn, rn, rd, imm};
    endfunction

    logic [31:0] beq;
    logic [31:0] ldr_r0;
    logic [31:0] cmp_r1r2;

    initial begin
        reset_n = 1'b0;
        bus_if.Instr = 32'h0;
        bus_if.ALUFlags = 4'h0;
        beq      = {4'b0000, 2'b10, 2'b10, 24'h000010};
        ldr_r0   = mem(4'hE, 6'b011001, 4'd1, 4'd0, 12'd8);
        cmp_r1r2 = dp(4'hE, 1'b0, 4'b1010, 1'b1, 4'd1, 4'd0, 12'd2);

        cycle("reset0", S_FETCH, 32'hE0000000, 4'h0, 1'b0, 1'b0);
        cycle("reset1", S_FETCH, 32'hE0000000, 4'h0, 1'b0, 1'b0);

        run("ADDS",     K_DPI, dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd2, 4'd1, 12'd5), 4'b0100, 1'b1);
        run("BEQ_t1",   K_B,   beq, 4'h0, 1'b1);
        run("CMP_z0",   K_DPR, cmp_r1r2, 4'b0000, 1'b1);
        run("BEQ_n1",   K_B,   beq, 4'h0, 1'b0);
        run("CMP_z1",   K_DPR, cmp_r1r2, 4'b0100, 1'b1);
        run("BEQ_t2",   K_B,   beq, 4'h0, 1'b1);
        run("LDR",      K_LDR, ldr_r0, 4'h0, 1'b1);
        run("ORR_pc",   K_DPR, dp(4'hE, 1'b0, 4'b1100, 1'b0, 4'd1, 4'd15, 12'd2), 4'b0000, 1'b1);
        run("ANDSNV",   K_DPR, dp(4'hF, 1'b0, 4'b0000, 1'b1, 4'd1, 4'd3, 12'd2), 4'b0000, 1'b0);
        run("BEQ_t3",   K_B,   beq, 4'h0, 1'b1);
        run("SUBS",     K_DPI, dp(4'hE, 1'b1, 4'b0010, 1'b1, 4'd1, 4'd4, 12'd1), 4'b1001, 1'b1);
        run("ADDGE",    K_DPI, dp(4'hA, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd5, 12'd3), 4'b0000, 1'b1);
        run("ADDLT",    K_DPI, dp(4'hB, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd5, 12'd3), 4'b0000, 1'b0);
        run("CMP_z0b",  K_DPR, cmp_r1r2, 4'b0000, 1'b1);
        run("STREQ",    K_STR, mem(4'h0, 6'b011000, 4'd1, 4'd2, 12'd4), 4'h0, 1'b0);
        run("LDR_pc",   K_LDR, mem(4'hE, 6'b011001, 4'd1, 4'd15, 12'd0), 4'h0, 1'b1);
        run("UNDEF",    K_UND, {4'hE, 2'b11, 26'h0}, 4'h0, 1'b0);
        run("CMP_z1b",  K_DPR, cmp_r1r2, 4'b0100, 1'b1);

        // Reset lands in the middle of an LDR: write enables drop, flags clear.
        cycle("ldr_rst.c0", S_FETCH,  ldr_r0, 4'h0, 1'b1, 1'b1);
        cycle("ldr_rst.c1", S_DECODE, ldr_r0, 4'h0, 1'b1, 1'b1);
        cycle("ldr_rst.c2", S_MEMADR, ldr_r0, 4'h0, 1'b1, 1'b1);
        cycle("ldr_rst.c3", S_MEMRD,  ldr_r0, 4'h0, 1'b1, 1'b0);
        $display("txn %-10s instr=%h cycles=4 compared=%0d", "LDR_RST", ldr_r0, n_cmp);
        run("BEQ_post", K_B, beq, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Multicycle ARM control unit. Decodes the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback cycles.
- Directly upstream of the immediate extender: drives ImmSrc alongside the Instr[23:0] field that the extender consumes.
- Owns the NZCV flags register and gates every architectural write by the instruction's condition field.

Parameters:
- none (ISA subset fixed: ADD, SUB, AND, ORR, CMP, LDR, STR, B).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- Instr  in  32  instruction register contents. Fields used: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  extender mode; always equals Op.
- RegSrc  out  2  register address select: [0] = (Op==10), [1] = (Op==01).

Behaviour:
State register:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Reset (reset_n low at a clock edge): state <= FETCH, flags <= 0000, CondEx latch <= 0.
- While reset_n is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. All other outputs are don't-care.

Transitions:
- FETCH -> DECODE.
- DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (undefined instruction, no writes).
- MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD -> MEMWB -> FETCH.
- MEMWR -> FETCH.
- EXECR / EXECI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
- Latencies: data-processing 4 cycles, LDR 5, STR 4, B 3.

Per-state raw controls (unlisted signals are 0):
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUOp=1, ALUSrcB=00.
- EXECI: ALUOp=1, ALUSrcB=01.
- ALUWB: RegW=1.
- BRANCH: Branch=1, ALUSrcB=01, ResultSrc=10.

ALU decode:
- ALUOp=0 -> ADD.
- ALUOp=1, by Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 SUB with NoWrite=1 (CMP). Any other code -> ADD.
- FlagW[1] = ALUOp & Funct[0] (updates N,Z).
- FlagW[0] = ALUOp & Funct[0] & (ALUControl is ADD or SUB) (updates C,V).

Conditions:
- Cond is evaluated against the flags register: EQ..LE per ARM, AL=1110 -> true, 1111 -> false.
- CondEx is latched at the end of DECODE and held until the next DECODE.

Gated outputs:
- RegWrite = RegW & CondEx & ~NoWrite.
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (Branch & CondEx) | (RegW & CondEx & ~NoWrite & Rd==1111).
- Flags update from ALUFlags at the EXECR/EXECI clock edge only when CondEx=1, per FlagW halves.
- A flag update and a condition evaluation never coincide: the next evaluation is in the following DECODE.

Decomposition:
- Shared package arm_mc_pkg: state enum, ALUControl encodings, ResultSrc / ALUSrcB encodings, Cond code constants.
- One sub-module, arm_cond_unit: flags register, condition evaluation and CondEx latch, with inputs clk, reset_n, Cond, ALUFlags, FlagW, latch strobe.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then release -> all write enables 0 during reset; first post-reset cycle has IRWrite=1, PCWrite=1, ALUSrcB=10.
- ADDS R1,R2,#5 (Cond=1110, Op=00, Funct=101001) -> state sequence FETCH, DECODE, EXECI, ALUWB; ImmSrc=00; ALUControl=00 in EXECI; RegWrite=1 in ALUWB; with ALUFlags=0100 the flags become Z=1.
- CMP R1,R2 (Funct=010101), then BEQ -> CMP gives RegWrite=0 in ALUWB and flags updated; BEQ in BRANCH gives PCWrite=1 and ImmSrc=10. With Z=0 instead, PCWrite=0 in BRANCH.
- LDR R0,[R1,#8] (Op=01, Funct[0]=1) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); 5 cycles total.
- STREQ with Z=0 -> MEMWR reached but MemWrite=0; next state FETCH.
- Op=11 -> DECODE returns to FETCH with no writes. Asserting reset_n=0 in the middle of MEMRD -> next state FETCH and flags cleared.
